// File: rtl/arc4_pkg.sv
// Shared types, constants and the hex glyph table for the ARC4 key cracker.
package arc4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA,
        ST_PRGA,
        ST_NEXT,
        ST_FOUND,
        ST_FAIL
    } state_e;

    localparam logic [7:0] ASCII_MIN = 8'h20;
    localparam logic [7:0] ASCII_MAX = 8'h7E;
    localparam logic [6:0] HEX_BLANK = 7'h7F;
    localparam logic [6:0] HEX_DASH  = 7'b0111111;

    // Active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/arc4_if.sv
// Single-port 256x8 memory bus; the engine is master, the RAM is slave.
interface arc4_mem_if;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       we;
    logic [7:0] rdata;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/arc4_ram.sv
// Inferred 256x8 single-port RAM, synchronous read with one cycle latency.
module arc4_ram (
    input logic      clk,
    arc4_mem_if.slave port
);
    logic [7:0] mem [256];

    always_ff @(posedge clk) begin
        if (port.we) mem[port.addr] <= port.wdata;
        port.rdata <= mem[port.addr];
    end
endmodule

// File: rtl/seg7_hex.sv
// Combinational nibble to active-low seven-segment decoder.
module seg7_hex
    import arc4_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    assign seg_o = hex7seg(nib_i);
endmodule

// File: rtl/task4_top.sv
// ARC4 24-bit key cracker: brute-forces keys until the ct decrypts to printable ASCII.
// Define PT_STORE_EN to keep the decoded plaintext in an extra 256x8 RAM named pt.
module task4_top
    import arc4_pkg::*;
#(
    parameter logic [23:0] KEY_START = 24'h000000,
    parameter logic [23:0] KEY_END   = 24'hFFFFFF
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [9:0] LEDR
);
    logic rst_n;
    logic unused_in;
    assign rst_n     = KEY[3];
    assign unused_in = ^{SW, KEY[2:0]};

    state_e      state_q;
    logic [23:0] key_q;
    logic [7:0]  i_q, j_q, n_q, len_q;
    logic [7:0]  si_q, sj_q;
    logic [2:0]  ph_q;
    logic [1:0]  km_q;
    logic [6:0]  hex_q [6];
    logic [1:0]  ledr_q;

    arc4_mem_if ct_bus ();
    arc4_mem_if s_bus ();

    arc4_ram ct (.clk(CLOCK_50), .port(ct_bus));
    arc4_ram s  (.clk(CLOCK_50), .port(s_bus));

    logic [6:0] seg [6];
    for (genvar g = 0; g < 6; g++) begin : g_seg
        seg7_hex u_seg (.nib_i(key_q[4*g +: 4]), .seg_o(seg[g]));
    end

    logic [7:0] kbyte, j_ksa, j_prga, p;
    logic       printable;

    assign kbyte = (km_q == 2'd0) ? key_q[23:16] :
                   (km_q == 2'd1) ? key_q[15:8]  : key_q[7:0];
    assign j_ksa     = j_q + s_bus.rdata + kbyte;
    assign j_prga    = j_q + s_bus.rdata;
    assign p         = s_bus.rdata ^ ct_bus.rdata;
    assign printable = (p >= ASCII_MIN) && (p <= ASCII_MAX);

    // ct[0] holds the length while not decoding, ct[n] during PRGA
    assign ct_bus.addr  = (state_q == ST_PRGA) ? n_q : 8'd0;
    assign ct_bus.wdata = 8'd0;
    assign ct_bus.we    = 1'b0;

    always_comb begin
        s_bus.addr  = i_q;
        s_bus.wdata = i_q;
        s_bus.we    = 1'b0;
        case (state_q)
            ST_INIT: s_bus.we = 1'b1;
            ST_KSA, ST_PRGA: begin
                case (ph_q)
                    3'd0: s_bus.addr = (state_q == ST_PRGA) ? i_q + 8'd1 : i_q;
                    3'd1: s_bus.addr = (state_q == ST_PRGA) ? j_prga : j_ksa;
                    3'd2: begin
                        s_bus.we    = 1'b1;
                        s_bus.wdata = s_bus.rdata;
                    end
                    3'd3: begin
                        s_bus.we    = 1'b1;
                        s_bus.addr  = j_q;
                        s_bus.wdata = si_q;
                    end
                    3'd4: s_bus.addr = si_q + sj_q;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

`ifdef PT_STORE_EN
    arc4_mem_if pt_bus ();
    arc4_ram pt (.clk(CLOCK_50), .port(pt_bus));

    logic unused_pt;
    assign pt_bus.addr  = (state_q == ST_PRGA) ? n_q : 8'd0;
    assign pt_bus.wdata = (state_q == ST_PRGA) ? p : len_q;
    assign pt_bus.we    = ((state_q == ST_PRGA) && (ph_q == 3'd5)) ||
                          ((state_q == ST_KSA) && (ph_q == 3'd0) && (i_q == 8'd0));
    assign unused_pt    = ^pt_bus.rdata;
`else
`endif

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            key_q   <= KEY_START;
            i_q     <= '0;
            j_q     <= '0;
            n_q     <= '0;
            len_q   <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            ph_q    <= '0;
            km_q    <= '0;
            ledr_q  <= '0;
            for (int d = 0; d < 6; d++) hex_q[d] <= HEX_BLANK;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    i_q     <= '0;
                    ledr_q  <= 2'b01;
                    state_q <= ST_INIT;
                end
                ST_INIT: begin
                    i_q <= i_q + 8'd1;
                    if (i_q == 8'hFF) begin
                        len_q   <= ct_bus.rdata;
                        j_q     <= '0;
                        ph_q    <= '0;
                        km_q    <= '0;
                        state_q <= ST_KSA;
                    end
                end
                ST_KSA: begin
                    case (ph_q)
                        3'd0: ph_q <= 3'd1;
                        3'd1: begin
                            j_q  <= j_ksa;
                            si_q <= s_bus.rdata;
                            ph_q <= 3'd2;
                        end
                        3'd2: ph_q <= 3'd3;
                        default: begin
                            ph_q <= '0;
                            i_q  <= i_q + 8'd1;
                            km_q <= (km_q == 2'd2) ? 2'd0 : km_q + 2'd1;
                            if (i_q == 8'hFF) begin
                                j_q     <= '0;
                                n_q     <= 8'd1;
                                state_q <= (len_q == 8'd0) ? ST_FOUND : ST_PRGA;
                            end
                        end
                    endcase
                end
                ST_PRGA: begin
                    case (ph_q)
                        3'd0: begin
                            i_q  <= i_q + 8'd1;
                            ph_q <= 3'd1;
                        end
                        3'd1: begin
                            j_q  <= j_prga;
                            si_q <= s_bus.rdata;
                            ph_q <= 3'd2;
                        end
                        3'd2: begin
                            sj_q <= s_bus.rdata;
                            ph_q <= 3'd3;
                        end
                        3'd3: ph_q <= 3'd4;
                        3'd4: ph_q <= 3'd5;
                        default: begin
                            ph_q <= '0;
                            n_q  <= n_q + 8'd1;
                            if (!printable)
                                state_q <= (key_q == KEY_END) ? ST_FAIL : ST_NEXT;
                            else if (n_q == len_q)
                                state_q <= ST_FOUND;
                        end
                    endcase
                end
                ST_NEXT: begin
                    key_q   <= key_q + 24'd1;
                    i_q     <= '0;
                    state_q <= ST_INIT;
                end
                ST_FOUND: begin
                    ledr_q <= 2'b10;
                    for (int d = 0; d < 6; d++) hex_q[d] <= seg[d];
                end
                ST_FAIL: begin
                    ledr_q <= 2'b00;
                    for (int d = 0; d < 6; d++) hex_q[d] <= HEX_DASH;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];
    assign LEDR = {8'd0, ledr_q};

endmodule

// File: tb/tb_task4_top.sv
// Bench for task4_top: three instances with different key ranges against a software ARC4 search.
module tb_task4_top;
    import arc4_pkg::*;

    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] key_a = 4'b0000;
    logic [3:0] key_b = 4'b0000;
    logic [3:0] key_c = 4'b0000;
    logic [9:0] sw = '0;

    logic [6:0] hx_a [6];
    logic [6:0] hx_b [6];
    logic [6:0] hx_c [6];
    logic [9:0] led_a, led_b, led_c;
    logic [41:0] seg_a, seg_b, seg_c;

    assign seg_a = {hx_a[5], hx_a[4], hx_a[3], hx_a[2], hx_a[1], hx_a[0]};
    assign seg_b = {hx_b[5], hx_b[4], hx_b[3], hx_b[2], hx_b[1], hx_b[0]};
    assign seg_c = {hx_c[5], hx_c[4], hx_c[3], hx_c[2], hx_c[1], hx_c[0]};

    task4_top dut_a (
        .CLOCK_50(clk), .KEY(key_a), .SW(sw),
        .HEX0(hx_a[0]), .HEX1(hx_a[1]), .HEX2(hx_a[2]),
        .HEX3(hx_a[3]), .HEX4(hx_a[4]), .HEX5(hx_a[5]),
        .LEDR(led_a)
    );

    task4_top #(.KEY_END(24'h00000F)) dut_b (
        .CLOCK_50(clk), .KEY(key_b), .SW(sw),
        .HEX0(hx_b[0]), .HEX1(hx_b[1]), .HEX2(hx_b[2]),
        .HEX3(hx_b[3]), .HEX4(hx_b[4]), .HEX5(hx_b[5]),
        .LEDR(led_b)
    );

    task4_top #(.KEY_START(24'h0A0B0A), .KEY_END(24'h0A0B0D)) dut_c (
        .CLOCK_50(clk), .KEY(key_c), .SW(sw),
        .HEX0(hx_c[0]), .HEX1(hx_c[1]), .HEX2(hx_c[2]),
        .HEX3(hx_c[3]), .HEX4(hx_c[4]), .HEX5(hx_c[5]),
        .LEDR(led_c)
    );

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] ptm [256];
    logic [7:0] ctm [256];
    logic [7:0] pad [256];
    int msg_len;

    // Reference ARC4 keystream for a 3-byte key
    function automatic void gen_pad(input logic [23:0] k, input int len);
        int s [256];
        int kb [3];
        int i, j, t;
        kb[0] = int'(k[23:16]);
        kb[1] = int'(k[15:8]);
        kb[2] = int'(k[7:0]);
        for (int x = 0; x < 256; x++) s[x] = x;
        j = 0;
        for (int x = 0; x < 256; x++) begin
            j = (j + s[x] + kb[x % 3]) % 256;
            t = s[x]; s[x] = s[j]; s[j] = t;
        end
        i = 0;
        j = 0;
        for (int n = 1; n <= len; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            pad[n] = 8'(s[(s[i] + s[j]) % 256]);
        end
    endfunction

    function automatic void make_plain();
        for (int n = 1; n <= msg_len; n++)
            ptm[n] = 8'($urandom_range(32, 126));
    endfunction

    function automatic void encrypt(input logic [23:0] k);
        gen_pad(k, msg_len);
        for (int x = 0; x < 256; x++) ctm[x] = 8'd0;
        ctm[0] = 8'(msg_len);
        for (int n = 1; n <= msg_len; n++) ctm[n] = ptm[n] ^ pad[n];
    endfunction

    function automatic void model_search(input logic [23:0] ks, input logic [23:0] ke,
                                         output bit found, output logic [23:0] fk);
        bit ok;
        int pv;
        found = 1'b0;
        fk = '0;
        for (int unsigned k = ks; k <= ke; k++) begin
            ok = 1'b1;
            gen_pad(k[23:0], msg_len);
            for (int n = 1; n <= msg_len; n++) begin
                pv = int'(ctm[n] ^ pad[n]);
                if (pv < 32 || pv > 126) ok = 1'b0;
                if (!ok) break;
            end
            if (ok) begin
                found = 1'b1;
                fk = k[23:0];
                return;
            end
        end
    endfunction

    function automatic logic [41:0] exp_seg(input bit found, input logic [23:0] k);
        logic [41:0] r;
        for (int g = 0; g < 6; g++)
            r[7*g +: 7] = found ? GLYPH[k[4*g +: 4]] : DASH;
        return r;
    endfunction

    function automatic logic [9:0] exp_led(input bit found);
        return found ? 10'b0000000010 : 10'b0000000000;
    endfunction

    task automatic load_a();
        for (int x = 0; x < 256; x++) dut_a.ct.mem[x] = ctm[x];
    endtask

    task automatic load_b();
        for (int x = 0; x < 256; x++) dut_b.ct.mem[x] = ctm[x];
    endtask

    task automatic load_c();
        for (int x = 0; x < 256; x++) dut_c.ct.mem[x] = ctm[x];
    endtask

    task automatic run_c(output bit done);
        key_c = 4'b0111;
        repeat (2) @(negedge clk);
        load_c();
        key_c = 4'b1111;
        done = 1'b0;
        for (int c = 0; c < 20000 && !done; c++) begin
            @(negedge clk);
            if (led_c[1] || hx_c[0] == DASH) done = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (seg_a !== {6{BLANK}}) begin
            $display("FAIL reset_hex_a: got %h want %h", seg_a, {6{BLANK}});
            n_fail++;
        end
        n_checks++;
        if (led_a !== 10'd0) begin
            $display("FAIL reset_led_a: got %b want 0", led_a);
            n_fail++;
        end
        n_checks++;
        if (seg_b !== {6{BLANK}}) begin
            $display("FAIL reset_hex_b: got %h want %h", seg_b, {6{BLANK}});
            n_fail++;
        end
        n_checks++;
        if (led_c !== 10'd0 || seg_c !== {6{BLANK}}) begin
            $display("FAIL reset_c: got led %b hex %h want 0 / blank", led_c, seg_c);
            n_fail++;
        end
    endtask

    task automatic test_search();
        bit fa, fb, da, db;
        logic [23:0] ka, kb, maxk;
        int cyc;
        int bad;
        msg_len = 20;
        make_plain();
        encrypt(24'h000018);
        load_a();
        load_b();
        model_search(24'h000000, 24'hFFFFFF, fa, ka);
        model_search(24'h000000, 24'h00000F, fb, kb);
        @(negedge clk);
        key_a = 4'b1111;
        key_b = 4'b1111;
        repeat (10) @(negedge clk);
        n_checks++;
        if (led_a !== 10'd1) begin
            $display("FAIL busy_led: got %b want 0000000001", led_a);
            n_fail++;
        end
        n_checks++;
        if (seg_a !== {6{BLANK}}) begin
            $display("FAIL busy_hex: got %h want %h", seg_a, {6{BLANK}});
            n_fail++;
        end
        cyc = 0;
        while (!(dut_a.key_q == 24'd2 && dut_a.state_q == ST_PRGA) && cyc < 10000) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc >= 10000) begin
            $display("FAIL mid_prga_wait: waited %0d cycles, limit 10000", cyc);
            n_fail++;
        end
        #2 key_a = 4'b0111;
        #1;
        n_checks++;
        if (led_a !== 10'd0 || seg_a !== {6{BLANK}}) begin
            $display("FAIL async_reset: got led %b hex %h want 0 / blank", led_a, seg_a);
            n_fail++;
        end
        repeat (2) @(negedge clk);
        key_a = 4'b1111;
        maxk = '0;
        da = 1'b0;
        db = 1'b0;
        cyc = 0;
        while (!(da && db) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (dut_b.key_q > maxk) maxk = dut_b.key_q;
            if (led_a[1] || hx_a[0] == DASH) da = 1'b1;
            if (led_b[1] || hx_b[0] == DASH) db = 1'b1;
        end
        n_checks++;
        if (!da || !db) begin
            $display("FAIL search_done: got done a=%0d b=%0d want 1 1", da, db);
            n_fail++;
        end
        n_checks++;
        if (seg_a !== exp_seg(fa, ka)) begin
            $display("FAIL found_hex: got %h want %h", seg_a, exp_seg(fa, ka));
            n_fail++;
        end
        n_checks++;
        if (led_a !== exp_led(fa)) begin
            $display("FAIL found_led: got %b want %b", led_a, exp_led(fa));
            n_fail++;
        end
        n_checks++;
        if (seg_b !== exp_seg(fb, kb)) begin
            $display("FAIL keyend_hex: got %h want %h", seg_b, exp_seg(fb, kb));
            n_fail++;
        end
        n_checks++;
        if (led_b !== exp_led(fb)) begin
            $display("FAIL keyend_led: got %b want %b", led_b, exp_led(fb));
            n_fail++;
        end
        n_checks++;
        if (maxk > 24'h00000F) begin
            $display("FAIL keyend_range: got max key %h want <= 00000F", maxk);
            n_fail++;
        end
        bad = 0;
        for (int x = 0; x < 256; x++)
            if (dut_a.ct.mem[x] !== ctm[x]) bad++;
        n_checks++;
        if (bad != 0) begin
            $display("FAIL ct_intact: got %0d changed bytes want 0", bad);
            n_fail++;
        end
    endtask

    task automatic test_len0();
        bit f, done;
        logic [23:0] k;
        key_a = 4'b0111;
        msg_len = 0;
        encrypt(24'h000000);
        repeat (2) @(negedge clk);
        load_a();
        model_search(24'h000000, 24'hFFFFFF, f, k);
        key_a = 4'b1111;
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            if (led_a[1] || hx_a[0] == DASH) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            $display("FAIL len0_done: got timeout want found within 3000 cycles");
            n_fail++;
        end
        n_checks++;
        if (seg_a !== exp_seg(f, k) || led_a !== exp_led(f)) begin
            $display("FAIL len0_result: got hex %h led %b want %h %b",
                     seg_a, led_a, exp_seg(f, k), exp_led(f));
            n_fail++;
        end
    endtask

    task automatic test_ascii_edges();
        bit f, done;
        logic [23:0] k;
        msg_len = 24;
        make_plain();
        ptm[1]  = 8'h7E;
        ptm[5]  = 8'h20;
        ptm[17] = 8'h7E;
        ptm[24] = 8'h20;
        encrypt(24'h0A0B0C);
        model_search(24'h0A0B0A, 24'h0A0B0D, f, k);
        run_c(done);
        n_checks++;
        if (!done) begin
            $display("FAIL edges_done: got timeout want finish within 20000 cycles");
            n_fail++;
        end
        n_checks++;
        if (seg_c !== exp_seg(f, k)) begin
            $display("FAIL edges_hex: got %h want %h", seg_c, exp_seg(f, k));
            n_fail++;
        end
        n_checks++;
        if (led_c !== exp_led(f)) begin
            $display("FAIL edges_led: got %b want %b", led_c, exp_led(f));
            n_fail++;
        end
    endtask

    task automatic test_reject(input logic [7:0] bad, input logic [23:0] enc_key);
        bit f, done;
        logic [23:0] k;
        msg_len = 12;
        make_plain();
        ptm[$urandom_range(1, 12)] = bad;
        encrypt(enc_key);
        model_search(24'h0A0B0A, 24'h0A0B0D, f, k);
        run_c(done);
        n_checks++;
        if (!done) begin
            $display("FAIL reject_%h_done: got timeout want finish", bad);
            n_fail++;
        end
        n_checks++;
        if (seg_c !== exp_seg(f, k) || led_c !== exp_led(f)) begin
            $display("FAIL reject_%h: got hex %h led %b want %h %b",
                     bad, seg_c, led_c, exp_seg(f, k), exp_led(f));
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_search();
        test_len0();
        test_ascii_edges();
        test_reject(8'h7F, 24'h0A0B0B);
        test_reject(8'h1F, 24'h0A0B0C);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
